// File: rtl/des_pkg.sv
// des_pkg: shared constants and helpers for the DES round engine.
// - FIPS 46-3 PC-1, PC-2, E, P tables and the eight S-boxes. Entries use
//   FIPS numbering: bit 1 is the MSB of the source word.
// - Per-round key shift schedule, FSM state type, key widths.
// - Permutation and 28-bit rotate helpers.
package des_pkg;

  localparam int SUBKEY_W   = 48;
  localparam int HALF_KEY_W = 28;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Left-rotate amount applied before forming K1..K16. Index 0 is round 1.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Row-major (row 0 cols 0..15, row 1 ...), so the lookup index is
  // {b1, b6, b2, b3, b4, b5} of the 6-bit input chunk.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  // Each helper builds its output MSB-first by shifting in one selected bit.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r = {r[54:0], key[6'(64 - PC1_TBL[6'(j)])]};
    return r;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
    logic [SUBKEY_W-1:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r = {r[46:0], cd[6'(56 - PC2_TBL[6'(j)])]};
    return r;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r = {r[46:0], x[5'(32 - E_TBL[6'(j)])]};
    return r;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) r = {r[30:0], x[5'(32 - P_TBL[5'(j)])]};
    return r;
  endfunction

  function automatic logic [HALF_KEY_W-1:0] rotl28(input logic [HALF_KEY_W-1:0] x,
                                                   input logic [1:0] sh);
    case (sh)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [HALF_KEY_W-1:0] rotr28(input logic [HALF_KEY_W-1:0] x,
                                                   input logic [1:0] sh);
    case (sh)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// des_f: combinational DES round function f(R, K).
// The datapath is E-expansion, then XOR with the subkey, then eight S-box
// lookups, then the P permutation.
// Ports:
//   r_i [31:0]  right half of the block
//   k_i [47:0]  round subkey
//   f_o [31:0]  f(R, K)
module des_f
  import des_pkg::*;
(
  input  logic [31:0]         r_i,
  input  logic [SUBKEY_W-1:0] k_i,
  output logic [31:0]         f_o
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  assign w_x = e_expand(r_i) ^ k_i;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0] w_b;
    assign w_b = w_x[47-6*g -: 6];
    // The outer bits select the row and the inner four bits select the column.
    assign w_s[31-4*g -: 4] = 4'(SBOX[g][{w_b[5], w_b[0], w_b[4:1]}]);
  end

  assign f_o = p_perm(w_s);

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel core that computes one round per clock.
// It takes the IP output and the key, and returns R16||L16 for the final
// permutation stage.
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   valid_i/ready_o    input handshake; a block is accepted only in IDLE
//   data_i [63:0]      L0||R0
//   key_i  [63:0]      DES key, MSB = FIPS bit 1; parity bits are unused
//   decrypt_i          1 = decrypt; latched when the block is accepted
//   valid_o/ready_i    output handshake; data_o is held until ready_i
//   data_o [63:0]      R16||L16
//
// state | meaning
// IDLE  | waiting for a block; ready_o=1
// ROUND | one Feistel round per clock, ROUNDS clocks in total
// DONE  | result held on data_o, valid_o=1 until ready_i
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS = 16  // 1..16; anything other than 16 is for debug only
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] data_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] data_o
);

  state_t r_state, w_state_next;
  logic [3:0]            r_cnt;
  logic [31:0]           r_l, r_r;
  logic [HALF_KEY_W-1:0] r_c, r_d;
  logic                  r_decrypt;
  logic [63:0]           r_data;

  logic                  w_accept, w_last;
  logic [55:0]           w_cd_pc1;
  logic [HALF_KEY_W-1:0] w_c_use, w_d_use, w_c_next, w_d_next;
  logic [SUBKEY_W-1:0]   w_subkey;
  logic [31:0]           w_f, w_r_next;

  assign w_accept = valid_i && ready_o;
  assign w_last   = (r_cnt == 4'(ROUNDS - 1));
  assign w_cd_pc1 = pc1(key_i);

  // Encrypt rotates left before using C/D, and the rotated value is stored.
  // Decrypt uses the stored C/D as-is, then rotates right by the schedule
  // entry of round 16-cnt. Round 1 therefore sees the unrotated PC-1 value.
  // Across 16 rounds, both modes rotate by a total of 28 bits, so C/D end
  // on PC-1 again.
  assign w_c_use  = r_decrypt ? r_c : rotl28(r_c, SHIFT_SCHED[r_cnt]);
  assign w_d_use  = r_decrypt ? r_d : rotl28(r_d, SHIFT_SCHED[r_cnt]);
  assign w_c_next = r_decrypt ? rotr28(r_c, SHIFT_SCHED[~r_cnt]) : w_c_use;
  assign w_d_next = r_decrypt ? rotr28(r_d, SHIFT_SCHED[~r_cnt]) : w_d_use;
  assign w_subkey = pc2({w_c_use, w_d_use});

  des_f u_f (
    .r_i (r_r),
    .k_i (w_subkey),
    .f_o (w_f)
  );

  assign w_r_next = r_l ^ w_f;
  assign data_o   = r_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_state_next = ROUND;
      end
      ROUND: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt     <= '0;
      r_l       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_decrypt <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_l       <= data_i[63:32];
            r_r       <= data_i[31:0];
            r_c       <= w_cd_pc1[55:28];
            r_d       <= w_cd_pc1[27:0];
            r_decrypt <= decrypt_i;
            r_cnt     <= '0;
          end
        end
        ROUND: begin
          r_l   <= r_r;
          r_r   <= w_r_next;
          r_c   <= w_c_next;
          r_d   <= w_d_next;
          r_cnt <= r_cnt + 4'd1;
          // The final swap is built in: R16 goes to the upper half.
          if (w_last) r_data <= {w_r_next, r_r};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;
  import des_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        decrypt_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [63:0] data_i = '0;
  logic [63:0] key_i = '0;
  logic        ready_o, valid_o;
  logic [63:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  localparam logic [63:0] K_FIPS  = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] PT_IP   = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] CT_PRE  = 64'h0A4CD995_43423234;
  localparam logic [55:0] CD_FIPS = 56'hF0CCAAF_556678F;
  localparam logic [47:0] K1_FIPS = 48'h1B02EFFC7072;

  des_round_engine dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .key_i     (key_i),
    .decrypt_i (decrypt_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference model: all 16 subkeys are precomputed by left rotation, and
  // decrypt simply walks that list backwards.
  function automatic logic [27:0] m_rotl(input logic [27:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[26:0], x[27]};
    return x;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [33:0] rr;
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    rr = {r[0], r, r[31]};
    x = '0;
    for (int i = 0; i < 8; i++) x = {x[41:0], 6'(rr >> (28 - 4*i))};
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = 6'(x >> (42 - 6*i));
      s = {s[27:0], 4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}])};
    end
    return p_perm(s);
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data,
                                          input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    cd = pc1(key);
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = m_rotl(c, int'(SHIFT_SCHED[4'(i)]));
      d = m_rotl(d, int'(SHIFT_SCHED[4'(i)]));
      ks[4'(i)] = pc2({c, d});
    end
    l = data[63:32];
    r = data[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, dec ? ks[4'(15 - i)] : ks[4'(i)]);
      l = t;
    end
    return {r, l};
  endfunction

  task automatic accept_block(input logic [63:0] k, input logic [63:0] d, input logic dec,
                              output int acc_cyc);
    @(negedge clk_i);
    key_i = k;
    data_i = d;
    decrypt_i = dec;
    valid_i = 1'b1;
    for (int i = 0; i < 100 && !ready_o; i++) @(negedge clk_i);
    chk("accept_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp, input int acc_cyc,
                           input bit churn);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (churn) begin
        key_i = {$urandom, $urandom};
        data_i = {$urandom, $urandom};
        decrypt_i = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "_valid"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd16);
    chk({tag, "_data"}, data_o, exp);
  endtask

  logic [63:0] b_key [200];
  logic [63:0] b_dat [200];
  logic [63:0] b_exp [200];
  bit          b_dec [200];

  initial begin
    int acc;
    logic [63:0] k, d, ct;

    ready_i = 1'b1;
    #12;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o", data_o, 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_cnt", 64'(dut.r_cnt), 64'd0);
    chk("rst_lr", {dut.r_l, dut.r_r}, 64'd0);
    chk("rst_cd", 64'({dut.r_c, dut.r_d}), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rel_ready_o", 64'(ready_o), 64'd1);
    chk("rel_valid_o", 64'(valid_o), 64'd0);

    // FIPS encrypt vector with round-1 internals
    accept_block(K_FIPS, PT_IP, 1'b0, acc);
    chk("enc_k1", 64'(dut.w_subkey), 64'(K1_FIPS));
    chk("enc_busy_ready", 64'(ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("enc_r1_l", 64'(dut.r_l), 64'hF0AAF0AA);
    chk("enc_r1_r", 64'(dut.r_r), 64'hEF4A6544);
    wait_done("enc", CT_PRE, acc, 1'b0);
    chk("enc_cd", 64'({dut.r_c, dut.r_d}), 64'(CD_FIPS));

    // FIPS decrypt vector
    accept_block(K_FIPS, CT_PRE, 1'b1, acc);
    wait_done("dec", PT_IP, acc, 1'b0);
    chk("dec_cd", 64'({dut.r_c, dut.r_d}), 64'(CD_FIPS));

    // Backpressure in DONE
    @(negedge clk_i);
    ready_i = 1'b0;
    accept_block(K_FIPS, PT_IP, 1'b0, acc);
    wait_done("bp", CT_PRE, acc, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_hold_valid", 64'(valid_o), 64'd1);
      chk("bp_hold_data", data_o, CT_PRE);
      chk("bp_hold_ready", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("bp_release_valid", 64'(valid_o), 64'd0);
    chk("bp_release_ready", 64'(ready_o), 64'd1);

    // Input churn while busy
    accept_block(K_FIPS, PT_IP, 1'b0, acc);
    wait_done("churn", CT_PRE, acc, 1'b1);

    // Async reset during round 7, then a fresh block
    accept_block(K_FIPS, PT_IP, 1'b0, acc);
    repeat (6) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid_o", 64'(valid_o), 64'd0);
    chk("arst_data_o", data_o, 64'd0);
    chk("arst_ready_o", 64'(ready_o), 64'd1);
    chk("arst_cnt", 64'(dut.r_cnt), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    accept_block(K_FIPS, PT_IP, 1'b0, acc);
    wait_done("post_rst", CT_PRE, acc, 1'b0);

    // Back-to-back: random encrypts, each followed by its round-trip decrypt
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom};
      d = {$urandom, $urandom};
      ct = des_ref(k, d, 1'b0);
      b_key[2*i] = k;   b_dat[2*i] = d;    b_dec[2*i] = 1'b0;   b_exp[2*i] = ct;
      b_key[2*i+1] = k; b_dat[2*i+1] = ct; b_dec[2*i+1] = 1'b1; b_exp[2*i+1] = d;
    end
    @(negedge clk_i);
    fork
      begin : drv
        int last, w, sp;
        last = 0;
        for (int i = 0; i < 200; i++) begin
          if (i > 0) @(negedge clk_i);
          key_i = b_key[i];
          data_i = b_dat[i];
          decrypt_i = b_dec[i];
          valid_i = 1'b1;
          w = 0;
          while (!ready_o && w < 400) begin
            @(negedge clk_i);
            w++;
          end
          if (!ready_o) begin
            chk("b2b_accept_timeout", 64'(ready_o), 64'd1);
            break;
          end
          @(posedge clk_i);
          #1;
          if (i > 0) begin
            sp = cyc - last;
            chk("b2b_spacing_ge18", 64'((sp >= 18) ? 18 : sp), 64'd18);
          end
          last = cyc;
        end
        valid_i = 1'b0;
      end
      begin : mon
        int w;
        bit got;
        for (int i = 0; i < 200; i++) begin
          w = 0;
          got = 1'b0;
          while (!got && w < 400) begin
            @(negedge clk_i);
            ready_i = 1'($urandom_range(0, 1));
            w++;
            if (valid_o && ready_i) got = 1'b1;
          end
          if (!got) begin
            chk("b2b_out_timeout", 64'(got), 64'd1);
            break;
          end
          chk(b_dec[i] ? "b2b_roundtrip" : "b2b_encrypt", data_o, b_exp[i]);
        end
        ready_i = 1'b1;
      end
    join

    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
